mem_port: RTL

Memory-side responder for the sequencer's load/store strobes. It accepts the MAR load, read request, RAM write and BYTE_ENABLE controls that the instruction decoder emits during READ/EXEC, and runs them as one or two byte transactions on an 8-bit request/acknowledge RAM bus. It assembles 16-bit read data for the MDR mux (MDRS_RAM input) and reports BUSY/DONE, so the sequencer can stall when memory inserts wait states.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_port.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and byte-enable constants for mem_port
//
// Purpose : one-hot sequencer states and BYTE_ENABLE lane codes used by the
//           memory-side responder.
// Contents: state_t (IDLE/LO/HI/FIN), BE_WORD/BE_LO/BE_HI/BE_NONE.
package mem_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LO   = 4'b0010,
        HI   = 4'b0100,
        FIN  = 4'b1000
    } state_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_NONE = 2'b00;

endpackage

// File: rtl/mem_port.sv
// rtl/mem_port.sv - byte-wide request/acknowledge RAM port for the sequencer
//
// Purpose : accepts MAR load, read and write strobes from the decoder and runs
//           them as one or two byte transactions on an 8-bit req/ack RAM bus,
//           assembling 16-bit read data and reporting BUSY/DONE.
// Ports   :
//   clk, reset           clock, synchronous active-high reset
//   MAR_LOAD, MAR_IN     load internal MAR (ignored while BUSY)
//   RD_REQ, RAM_LOAD     start read / write (write wins if both)
//   BYTE_ENABLE          11 word, 01 low byte, 10 high byte, 00 none
//   WDATA                16-bit store data
//   RDATA                assembled read data, registered
//   DONE, BUSY           completion pulse / request in progress
//   MEM_REQ, MEM_WE,
//   MEM_ADDR, MEM_WDATA  RAM bus request side
//   MEM_RDATA, MEM_ACK   RAM bus response side
module mem_port
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MAR_LOAD,
    input  logic [ADDR_W-1:0] MAR_IN,
    input  logic              RD_REQ,
    input  logic              RAM_LOAD,
    input  logic [1:0]        BYTE_ENABLE,
    input  logic [15:0]       WDATA,
    output logic [15:0]       RDATA,
    output logic              DONE,
    output logic              BUSY,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    input  logic [7:0]        MEM_RDATA,
    input  logic              MEM_ACK
);

    state_t              state_q;
    logic [ADDR_W-1:0]   mar_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          be_q;
    logic                we_q;
    logic [15:0]         wbuf_q;
    logic [15:0]         rdata_q;

    logic [ADDR_W-1:0]   eff_addr_d;
    logic                start_d;
    logic                in_lo;
    logic                in_hi;

    // A MAR load in the accept cycle is forwarded straight to the request.
    assign eff_addr_d = MAR_LOAD ? MAR_IN : mar_q;
    assign start_d    = RAM_LOAD | RD_REQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mar_q   <= '0;
            addr_q  <= '0;
            be_q    <= BE_NONE;
            we_q    <= 1'b0;
            wbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MAR_LOAD) begin
                        mar_q <= MAR_IN;
                    end
                    if (start_d) begin
                        addr_q <= eff_addr_d;
                        be_q   <= BYTE_ENABLE;
                        we_q   <= RAM_LOAD;
                        wbuf_q <= WDATA;
                        // Clearing here leaves unread lanes of byte reads at zero.
                        if (!RAM_LOAD) begin
                            rdata_q <= '0;
                        end
                        case (BYTE_ENABLE)
                            BE_WORD, BE_LO: state_q <= LO;
                            BE_HI:          state_q <= HI;
                            default:        state_q <= FIN;
                        endcase
                    end
                end
                LO: begin
                    if (MEM_ACK) begin
                        if (!we_q) begin
                            rdata_q[7:0] <= MEM_RDATA;
                        end
                        state_q <= (be_q == BE_WORD) ? HI : FIN;
                    end
                end
                HI: begin
                    if (MEM_ACK) begin
                        if (!we_q) begin
                            rdata_q[15:8] <= MEM_RDATA;
                        end
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_lo = (state_q == LO);
    assign in_hi = (state_q == HI);

    // Bus outputs come only from state and latched request data, so they stay
    // put for the whole phase however long the memory holds off MEM_ACK.
    // Outside LO/HI they are forced to zero.
    always_comb begin
        MEM_ADDR = '0;
        if (in_lo) begin
            MEM_ADDR = (be_q == BE_WORD) ? {addr_q[ADDR_W-1:1], 1'b0} : addr_q;
        end else if (in_hi) begin
            MEM_ADDR = {addr_q[ADDR_W-1:1], 1'b1};
        end
    end

    assign MEM_REQ   = in_lo | in_hi;
    assign MEM_WE    = MEM_REQ & we_q;
    assign MEM_WDATA = MEM_WE ? (in_hi ? wbuf_q[15:8] : wbuf_q[7:0]) : 8'h00;

    assign RDATA = rdata_q;
    assign DONE  = (state_q == FIN);
    assign BUSY  = (state_q != IDLE);

endmodule
